// File: rtl/ahb_prio_arbiter.sv
// ahb_prio_arbiter
//   Central AHB arbiter for a multi-master bus matrix. The highest hprior among requesting
//   masters wins. Equal priorities rotate round-robin, searching upward from the last winner.
//   Ownership changes only at legal AHB handover points: never inside a fixed-length burst,
//   and never while the owner holds hlock.
// Ports
//   hclk, hreset_n      clock; synchronous active-low reset
//   hbusreq, hlock      per-master bus request and locked-transfer request
//   hprior              per-master priority, master i at [i*PRIO_W +: PRIO_W]
//   htrans, hburst      HTRANS/HBURST of the current address-phase owner
//   hready              bus HREADY
//   hgrant              one-hot grant
//   hmaster, hmaster_d  address-phase and data-phase owner index
//   hmastlock           current address phase is locked
// The arbiter mode (park / own / burst / locked) is not stored. It follows from hbusreq,
// beat_cnt_q and hlock[hmaster].
module ahb_prio_arbiter #(
    parameter int unsigned MASNUM  = 4,
    parameter int unsigned PRIO_W  = 2,
    parameter int unsigned DEF_MAS = 0
) (
    input  logic                      hclk,
    input  logic                      hreset_n,
    input  logic [MASNUM-1:0]         hbusreq,
    input  logic [MASNUM-1:0]         hlock,
    input  logic [MASNUM*PRIO_W-1:0]  hprior,
    input  logic [1:0]                htrans,
    input  logic [2:0]                hburst,
    input  logic                      hready,
    output logic [MASNUM-1:0]         hgrant,
    output logic [$clog2(MASNUM)-1:0] hmaster,
    output logic [$clog2(MASNUM)-1:0] hmaster_d,
    output logic                      hmastlock
);

    localparam int unsigned IDX_W = $clog2(MASNUM);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;
    localparam logic [2:0] BURST_INCR   = 3'b001;

    logic [IDX_W-1:0]  hmaster_q, hmaster_dp_q, rr_ptr_q;
    logic              mastlock_q;
    logic [4:0]        beat_cnt_q, beat_cnt_d;
    logic [4:0]        burst_last;
    logic              accept, hp, any_req;
    logic [IDX_W-1:0]  win_idx;
    logic [PRIO_W-1:0] prio_arr [MASNUM];

    for (genvar g = 0; g < MASNUM; g++) begin : g_prio
        assign prio_arr[g] = hprior[g*PRIO_W +: PRIO_W];
    end

    assign accept  = hready & ((htrans == TRANS_NONSEQ) | (htrans == TRANS_SEQ));
    assign any_req = |hbusreq;

    // Beats remaining after the NONSEQ beat, decoded from HBURST[2:1].
    // SINGLE and INCR both decode to 0.
    always_comb begin
        burst_last = 5'd0;
        case (hburst[2:1])
            2'b00:   burst_last = 5'd0;
            2'b01:   burst_last = 5'd3;
            2'b10:   burst_last = 5'd7;
            default: burst_last = 5'd15;
        endcase
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (hready && htrans == TRANS_IDLE) begin
            beat_cnt_d = 5'd0;
        end else if (accept && htrans == TRANS_NONSEQ) begin
            beat_cnt_d = burst_last;
        end else if (accept && htrans == TRANS_SEQ && beat_cnt_q != 5'd0) begin
            beat_cnt_d = beat_cnt_q - 5'd1;
        end
    end

    // BUSY inside a fixed burst matches none of these terms, so it cannot hand over.
    assign hp = hready & ~hlock[hmaster_q] &
                ((htrans == TRANS_IDLE) |
                 (accept & (htrans == TRANS_NONSEQ) & (beat_cnt_d == 5'd0)) |
                 (accept & (htrans == TRANS_SEQ) & (beat_cnt_q == 5'd1)) |
                 (accept & (hburst == BURST_INCR)));

    // Search starts at rr_ptr+1 and wraps. A strict '>' keeps the first tied master in
    // search order, which makes equal priorities rotate.
    always_comb begin
        logic              found;
        logic [PRIO_W-1:0] best;
        int unsigned       idx;
        logic [IDX_W-1:0]  cand;
        found   = 1'b0;
        best    = '0;
        idx     = 0;
        cand    = '0;
        win_idx = IDX_W'(DEF_MAS);
        for (int unsigned k = 1; k <= MASNUM; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= MASNUM) idx = idx - MASNUM;
            cand = IDX_W'(idx);
            if (hbusreq[cand] && (!found || prio_arr[cand] > best)) begin
                found   = 1'b1;
                best    = prio_arr[cand];
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            hmaster_q    <= IDX_W'(DEF_MAS);
            hmaster_dp_q <= IDX_W'(DEF_MAS);
            rr_ptr_q     <= IDX_W'(DEF_MAS);
            mastlock_q   <= 1'b0;
            beat_cnt_q   <= 5'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            if (hready) hmaster_dp_q <= hmaster_q;
            if (hp) begin
                hmaster_q  <= win_idx;
                mastlock_q <= hlock[win_idx];
                if (any_req) rr_ptr_q <= win_idx;
            end else if (hready) begin
                mastlock_q <= hlock[hmaster_q];
            end
        end
    end

    // Grant is decoded from the registered owner, so it is one-hot and always matches hmaster.
    assign hgrant    = MASNUM'(1) << hmaster_q;
    assign hmaster   = hmaster_q;
    assign hmaster_d = hmaster_dp_q;
    assign hmastlock = mastlock_q;

endmodule
